// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

  localparam int XLEN = 32;

  // Register offsets inside the 8-byte window.
  localparam logic [2:0] TXDATA_OFF = 3'd0;
  localparam logic [2:0] STATUS_OFF = 3'd4;

  // STATUS bit positions.
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_SHIFTING  = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_MSB = 7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array is not reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, TX FIFO, overflow flag and serial FSM.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if more bytes queued
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR    = 32'h1000_0000,
  parameter int              CLKS_PER_BIT = 16,
  parameter int              FIFO_DEPTH   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] write_data,
  input  logic            we_memory,
  output logic [XLEN-1:0] read_data,
  output logic            sel,
  output logic            tx,
  output logic            busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state, state_n;
  logic [BW-1:0]  baud_cnt, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shifter, shifter_n;
  logic           tx_q, tx_n;
  logic           baud_end;

  logic           push_req;
  logic           push;
  logic           drop;
  logic           clear_ovf;
  logic           overflow;
  logic           pop;
  logic [7:0]     fifo_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           shifting;
  logic [XLEN-1:0] status;
  logic           unused_bits;

  assign sel       = (addr[XLEN-1:3] == BASE_ADDR[XLEN-1:3]);
  assign push_req  = we_memory & sel & (addr[2] == TXDATA_OFF[2]);
  assign push      = push_req & ~fifo_full;
  assign drop      = push_req & fifo_full;
  assign clear_ovf = we_memory & sel & (addr[2] == STATUS_OFF[2]) & write_data[ST_OVERFLOW];
  assign unused_bits = ^{addr[1:0], write_data[XLEN-1:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (write_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow: a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Serial FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shifter  <= shifter_n;
      tx_q     <= tx_n;
    end
  end

  assign baud_end = (baud_cnt == BAUD_LAST);

  // Next-state logic; tx is registered so the line changes on the same edge as the state.
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_idx;
    shifter_n = shifter;
    tx_n      = tx_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        bit_n  = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shifter_n = fifo_data;
          state_n   = START;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shifter[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n     = bit_idx + 1'b1;
            shifter_n = {1'b0, shifter[7:1]};
            tx_n      = shifter[1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          bit_n  = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shifter_n = fifo_data;
            state_n   = START;
            tx_n      = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign shifting = (state != IDLE);
  assign busy     = shifting | ~fifo_empty;
  assign tx       = tx_q;

  // STATUS word assembly and read mux.
  always_comb begin
    status = '0;
    status[ST_FULL]     = fifo_full;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_SHIFTING] = shifting;
    status[ST_OVERFLOW] = overflow;
    status[ST_COUNT_MSB:ST_COUNT_LSB] = 4'(fifo_count);
    read_data = '0;
    if (sel && (addr[2] == STATUS_OFF[2])) begin
      read_data = status;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench: stores push expected bytes, a line monitor decodes frames and compares.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        we_memory = 1'b0;
  logic [31:0] read_data;
  logic        sel;
  logic        tx;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int frames_rx = 0;
  logic [7:0] exp_q[$];

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .we_memory  (we_memory),
    .read_data  (read_data),
    .sel        (sel),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit expect_push);
    addr = a;
    write_data = d;
    we_memory = 1'b1;
    tick();
    we_memory = 1'b0;
    if (expect_push) exp_q.push_back(d[7:0]);
  endtask

  task automatic read_status(output logic [31:0] v);
    addr = BASE + 32'd4;
    #1;
    v = read_data;
  endtask

  // Line monitor: detects a start bit, samples each bit 1.5 cycles in, checks against scoreboard.
  logic       m_active = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_byte = '0;
  always @(negedge clk) begin
    if (!reset) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (tx === 1'b0) begin
        m_active = 1'b1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 1) begin
        chk("start_bit", {31'b0, tx}, 32'd0);
      end else if ((m_cnt % CPB) == 1 && m_cnt < 9 * CPB + 1) begin
        m_byte = {tx, m_byte[7:1]};
      end else if (m_cnt == 9 * CPB + 1) begin
        chk("stop_bit", {31'b0, tx}, 32'd1);
        frames_rx++;
        m_active = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: got %h expected none", m_byte);
        end else begin
          chk("frame_byte", {24'b0, m_byte}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st;
    logic [9:0]  frame;
    int          first_idle;
    int          f0;
    int          waited;

    // 1: reset
    repeat (3) tick();
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    read_status(st);
    chk("rst_status", st, 32'h2);
    reset = 1'b1;
    tick();

    // 2: single byte, bit-exact waveform
    store(BASE, 32'hA5, 1'b1);
    chk("t2_tx_at_store", {31'b0, tx}, 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      tick();
      chk("t2_tx_bit", {31'b0, tx}, {31'b0, frame[k / CPB]});
    end
    chk("t2_busy_last", {31'b0, busy}, 32'd1);
    tick();
    chk("t2_busy_fall", {31'b0, busy}, 32'd0);
    repeat (3) tick();

    // 3: back-to-back frames, no idle gap
    store(BASE, 32'h11, 1'b1);
    store(BASE, 32'h22, 1'b1);
    store(BASE, 32'h33, 1'b1);
    read_status(st);
    chk("t3_count_2", {28'b0, st[7:4]}, 32'd2);
    first_idle = 0;
    for (int k = 3; k <= 140 && first_idle == 0; k++) begin
      tick();
      if (k == 41) chk("t3_count_1", {28'b0, read_data[7:4]}, 32'd1);
      if (k == 81) chk("t3_count_0", {28'b0, read_data[7:4]}, 32'd0);
      if (read_data[2] == 1'b0) first_idle = k;
    end
    chk("t3_shift_span_end", first_idle, 32'd121);
    repeat (3) tick();

    // 4: overflow
    f0 = frames_rx;
    store(BASE, 32'h01, 1'b1);
    store(BASE, 32'h02, 1'b1);
    store(BASE, 32'h03, 1'b1);
    store(BASE, 32'h04, 1'b1);
    store(BASE, 32'h05, 1'b1);
    store(BASE, 32'h06, 1'b0);
    read_status(st);
    chk("t4_status_ovf", st, 32'h4D);
    store(BASE + 32'd4, 32'h8, 1'b0);
    read_status(st);
    chk("t4_status_clr", st, 32'h45);
    waited = 0;
    while (busy && waited < 300) begin
      tick();
      waited++;
    end
    chk("t4_idle_in_time", {31'b0, busy}, 32'd0);
    chk("t4_frames", frames_rx - f0, 32'd5);
    chk("t4_queue_drained", exp_q.size(), 32'd0);
    repeat (3) tick();

    // 5: decode
    addr = BASE + 32'd8;
    write_data = 32'h77;
    we_memory = 1'b1;
    #1;
    chk("t5_sel_above", {31'b0, sel}, 32'd0);
    tick();
    addr = BASE - 32'd4;
    #1;
    chk("t5_sel_below", {31'b0, sel}, 32'd0);
    tick();
    we_memory = 1'b0;
    addr = BASE;
    #1;
    chk("t5_sel_base", {31'b0, sel}, 32'd1);
    chk("t5_read_txdata", read_data, 32'd0);
    addr = BASE + 32'd6;
    #1;
    chk("t5_read_status", read_data, 32'h2);
    repeat (3) tick();
    chk("t5_no_push_busy", {31'b0, busy}, 32'd0);

    // 6: reset mid-frame
    f0 = frames_rx;
    store(BASE, 32'hC3, 1'b1);
    store(BASE, 32'h3C, 1'b1);
    store(BASE, 32'h96, 1'b1);
    repeat (10) tick();
    reset = 1'b0;
    tick();
    chk("t6_tx_after_rst", {31'b0, tx}, 32'd1);
    chk("t6_busy_after_rst", {31'b0, busy}, 32'd0);
    read_status(st);
    chk("t6_status_after_rst", st, 32'h2);
    exp_q.delete();
    reset = 1'b1;
    repeat (100) tick();
    chk("t6_no_frames", frames_rx - f0, 32'd0);
    chk("t6_tx_idle", {31'b0, tx}, 32'd1);
    chk("t6_busy_idle", {31'b0, busy}, 32'd0);

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
